// File: rtl/inst_buffer.sv
// Instruction FIFO between fetch and dual-issue decode; shows the two oldest entries each cycle.
// Optional same-cycle push bypass into empty slots is enabled by defining INST_BUF_BYPASS_EN.
module inst_buffer #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              push_en_i,
  input  logic [31:0]       push_inst_i,
  input  logic [31:0]       push_pc_i,
  input  logic [4:0]        push_exccode_i,
  input  logic [1:0]        pop_cnt_i,
  output logic [31:0]       inst1_o,
  output logic [31:0]       inst2_o,
  output logic [31:0]       pc1_o,
  output logic [31:0]       pc2_o,
  output logic [4:0]        exc1_o,
  output logic [4:0]        exc2_o,
  output logic              valid1_o,
  output logic              valid2_o,
  output logic              full_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o
);

  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] FULL_TH_C = (ADDR_W+1)'(DEPTH - FULL_MARGIN);

  logic [31:0] inst_mem_q [DEPTH];
  logic [31:0] pc_mem_q   [DEPTH];
  logic [4:0]  exc_mem_q  [DEPTH];

  logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d, head_nxt1;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [1:0]        pop_req, eff_pop;
  logic              bypass_pop, room, wr_en;

  always_comb begin
    pop_req = (pop_cnt_i == 2'd3) ? 2'd2 : pop_cnt_i;
    eff_pop = (count_q < (ADDR_W+1)'(pop_req)) ? count_q[1:0] : pop_req;
`ifdef INST_BUF_BYPASS_EN
    // Decode consumed the bypassed push along with every stored entry: nothing to retain.
    bypass_pop = push_en_i && (count_q < (ADDR_W+1)'(2)) && ((ADDR_W+1)'(pop_req) > count_q);
`else
    bypass_pop = 1'b0;
`endif
    room       = (count_q - (ADDR_W+1)'(eff_pop)) < DEPTH_C;
    wr_en      = push_en_i && !bypass_pop && room && !flush;
    head_d     = head_q + ADDR_W'(eff_pop);
    tail_d     = tail_q + ADDR_W'(wr_en);
    count_d    = count_q - (ADDR_W+1)'(eff_pop) + (ADDR_W+1)'(wr_en);
    overflow_d = overflow_q | (push_en_i && !room && !flush);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && wr_en) begin
      inst_mem_q[tail_q] <= push_inst_i;
      pc_mem_q[tail_q]   <= push_pc_i;
      exc_mem_q[tail_q]  <= push_exccode_i;
    end
  end

  always_comb begin
    head_nxt1 = head_q + ADDR_W'(1);
    valid1_o  = (count_q >= (ADDR_W+1)'(1));
    valid2_o  = (count_q >= (ADDR_W+1)'(2));
    inst1_o   = inst_mem_q[head_q];
    pc1_o     = pc_mem_q[head_q];
    exc1_o    = exc_mem_q[head_q];
    inst2_o   = inst_mem_q[head_nxt1];
    pc2_o     = pc_mem_q[head_nxt1];
    exc2_o    = exc_mem_q[head_nxt1];
`ifdef INST_BUF_BYPASS_EN
    if (push_en_i && count_q == '0) begin
      valid1_o = 1'b1;
      inst1_o  = push_inst_i;
      pc1_o    = push_pc_i;
      exc1_o   = push_exccode_i;
    end
    if (push_en_i && count_q == (ADDR_W+1)'(1)) begin
      valid2_o = 1'b1;
      inst2_o  = push_inst_i;
      pc2_o    = push_pc_i;
      exc2_o   = push_exccode_i;
    end
`endif
    // Empty slots read as zero so stale array contents never reach decode.
    if (!valid1_o) begin
      inst1_o = '0;
      pc1_o   = '0;
      exc1_o  = '0;
    end
    if (!valid2_o) begin
      inst2_o = '0;
      pc2_o   = '0;
      exc2_o  = '0;
    end
  end

  assign full_o     = (count_q >= FULL_TH_C);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Instruction queue between the fetch stage and the dual-issue decode stage.
- Accepts at most one fetched instruction per cycle, tagged with its PC and fetch exception code.
- Presents the two oldest entries to decode each cycle; decode retires 0, 1 or 2 of them.
- Drives the full indication that the fetch stage uses to withhold its instruction-memory enable.

Parameters:
- DEPTH, 16: number of entries; must be a power of two and at least 4.
- ADDR_W, 4: log2(DEPTH); pointer width.
- FULL_MARGIN, 2: free entries reserved for fetches already in flight when full_o rises.

Ports:
- clk  input  1  clock.
- resetn  input  1  reset, synchronous, active-low.
- flush  input  1  exception/redirect flush; empties the buffer.
- push_en_i  input  1  fetched instruction valid this cycle.
- push_inst_i  input  32  instruction word.
- push_pc_i  input  32  PC of the instruction.
- push_exccode_i  input  5  fetch exception code (EXC_NONE or EXC_AdEL).
- pop_cnt_i  input  2  entries decode consumes this cycle (0, 1, 2; 3 is treated as 2).
- inst1_o, inst2_o  output  32  oldest / second-oldest instruction.
- pc1_o, pc2_o  output  32  matching PCs.
- exc1_o, exc2_o  output  5  matching exception codes.
- valid1_o, valid2_o  output  1  slot holds a real entry.
- full_o  output  1  connects to the fetch stage's instBufferFull input.
- count_o  output  ADDR_W+1  current occupancy.
- overflow_o  output  1  sticky error: a push was dropped.

Behaviour:
- Storage: DEPTH entries of {inst, pc, exccode}, no reset needed on the array.
- Pointers:
  - head and tail are ADDR_W-bit and wrap modulo DEPTH.
  - count is ADDR_W+1 bits, so the range 0..DEPTH is representable.
- Reset (resetn=0 at posedge):
  - head=tail=count=0, overflow_o=0.
  - All valids 0, full_o=0.
  - Data outputs are 0 while their valid is 0.
- Read slots:
  - slot1 = entry[head]; slot2 = entry[head+1 mod DEPTH].
  - valid1_o = (count>=1); valid2_o = (count>=2).
- Pop:
  - eff_pop = min(pop_cnt_i clamped to 2, count).
  - head += eff_pop; popping beyond valid entries is silently clamped.
- Push:
  - Accepted when push_en_i and (count - eff_pop) < DEPTH.
  - On accept: entry[tail] written and tail += 1.
  - A push with count==DEPTH and eff_pop==0 is dropped and sets overflow_o; overflow_o is cleared only by reset.
- Count update: count_next = count - eff_pop + accepted push. Push and pop in the same cycle are both honoured.
- Push-to-visible latency: 1 cycle. The pushed entry appears at its slot the cycle after the write.
- full_o:
  - Combinational from registered count: full_o = (count >= DEPTH - FULL_MARGIN).
  - With defaults it asserts at count>=14.
  - The margin absorbs the one-cycle ice-to-data latency of instruction memory plus one registered stage.
- Flush:
  - Synchronous and priority over push/pop: head=tail=count=0.
  - Push and pop in the flush cycle are ignored; overflow_o is unchanged.
- Reset has priority over flush. Reset mid-operation discards all contents.
- Order is strict FIFO: slot1 is always older than slot2.

Optional Feature:
- Macro: INST_BUF_BYPASS_EN.
- Defined:
  - If count==0 and push_en_i, slot1 shows the push data combinationally in the same cycle and valid1_o=1.
  - If count==1 and push_en_i, slot2 shows the push data and valid2_o=1.
  - Whatever bypassed entries decode pops that cycle are not written into storage; tail advances only for entries retained.
  - Count and full_o are unaffected by bypass.
- Not defined: plain 1-cycle push-to-visible latency as above.

Test Plan:
- Reset then push 0x24010001 @pc 0xBFC00000 with pop=0: next cycle valid1=1, inst1=0x24010001, pc1=0xBFC00000, valid2=0, count=1.
- Push 3 entries (pcs 0x..00, 0x..04, 0x..08), then pop=2: slot1 pc=0x..00 and slot2 pc=0x..04 before the pop; after it count=1 and slot1 pc=0x..08.
- Push 14 entries with no pop: full_o=1 at count=14. Push 2 more: count=16, overflow_o=0. Push a 17th: dropped, overflow_o=1, count stays 16.
- count=16 with simultaneous push and pop=1: push accepted, count stays 16, no overflow. Run 40 cycles of push plus pop=1 to exercise pointer wrap with FIFO order intact.
- count=5 with flush plus push plus pop=2 in the same cycle: next cycle count=0, valid1=0, full_o=0.
- Push an entry with exccode=EXC_AdEL: exc1_o=EXC_AdEL when it reaches slot1. With INST_BUF_BYPASS_EN and an empty buffer, push plus pop=1: valid1=1 in the same cycle, count remains 0 next cycle.
